// File: rtl/rca_pkg.sv
// rca_pkg: shared defaults, slice-width helper and WIDTH/STAGES legality check for the pipelined RCA.
package rca_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction
endpackage

`define RCA_CHECK_PARAMS(W, S) \
    if ((S) < 1 || ((W) % (S)) != 0) begin : g_bad_params \
        $error("rca_pipe_nbit: WIDTH must be a positive multiple of STAGES"); \
    end

// File: rtl/rca_pipe_nbit_if.sv
// rca_pipe_nbit_if: operand/result streaming bus of the pipelined adder; overflow exists only with RCA_OVF_EN.
interface rca_pipe_nbit_if #(parameter int WIDTH = rca_pkg::DEF_WIDTH) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_start;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef RCA_OVF_EN
    logic             overflow;
    modport master (output in_valid, a, b, carry_start, out_ready,
                    input  in_ready, out_valid, sum, carry, overflow);
    modport slave  (input  in_valid, a, b, carry_start, out_ready,
                    output in_ready, out_valid, sum, carry, overflow);
`else
    modport master (output in_valid, a, b, carry_start, out_ready,
                    input  in_ready, out_valid, sum, carry);
    modport slave  (input  in_valid, a, b, carry_start, out_ready,
                    output in_ready, out_valid, sum, carry);
`endif
endinterface

// File: rtl/rca_slice.sv
// rca_slice: combinational W-bit ripple-carry adder built from full-adder cells.
module rca_slice #(parameter int W = 8) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    logic [W:0] c;
    assign c[0] = cin_i;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o = c[W];
endmodule

// File: rtl/rca_pipe_nbit.sv
// rca_pipe_nbit: pipelined WIDTH-bit ripple-carry adder, one slice per stage, full valid/ready backpressure.
// Defining RCA_OVF_EN adds a registered signed-overflow output aligned with sum.
module rca_pipe_nbit
    import rca_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input logic           clk,
    input logic           rst_n,
    rca_pipe_nbit_if.slave bus
);
    localparam int SW = slice_w(WIDTH, STAGES);
    `RCA_CHECK_PARAMS(WIDTH, STAGES)

    logic stall;
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Each stage keeps the finished low sum bits and only the operand bits not yet consumed.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int IW = WIDTH - k * SW;
        logic [IW-1:0]         ia, ib;
        logic                  ci, vin, co, vld_q, c_q;
        logic [SW-1:0]         ss;
        logic [(k+1)*SW-1:0]   s_d, s_q;
        if (k == 0) begin : g_first
            assign ia  = bus.a;
            assign ib  = bus.b;
            assign ci  = bus.carry_start;
            assign vin = bus.in_valid;
            assign s_d = ss;
        end else begin : g_next
            assign ia  = g_st[k-1].g_fwd.a_q;
            assign ib  = g_st[k-1].g_fwd.b_q;
            assign ci  = g_st[k-1].c_q;
            assign vin = g_st[k-1].vld_q;
            assign s_d = {ss, g_st[k-1].s_q};
        end
        rca_slice #(.W(SW)) u_slice (
            .a_i   (ia[SW-1:0]),
            .b_i   (ib[SW-1:0]),
            .cin_i (ci),
            .sum_o (ss),
            .cout_o(co)
        );
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
            end else if (!stall) begin
                vld_q <= vin;
                c_q   <= co;
                s_q   <= s_d;
            end
        if (k < STAGES - 1) begin : g_fwd
            logic [IW-SW-1:0] a_q, b_q;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= ia[IW-1:SW];
                    b_q <= ib[IW-1:SW];
                end
        end
    end

    assign bus.out_valid = g_st[STAGES-1].vld_q;
    assign bus.sum       = g_st[STAGES-1].s_q;
    assign bus.carry     = g_st[STAGES-1].c_q;

`ifdef RCA_OVF_EN
    logic ovf_d, ovf_q;
    // Carry into the MSB is a^b^sum at that bit, so it is recovered here rather than exported by the slice.
    assign ovf_d = g_st[STAGES-1].ia[SW-1] ^ g_st[STAGES-1].ib[SW-1]
                 ^ g_st[STAGES-1].ss[SW-1] ^ g_st[STAGES-1].co;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_q <= 1'b0;
        else if (!stall) ovf_q <= ovf_d;
    assign bus.overflow = ovf_q;
`endif
endmodule

// File: tb/tb_rca_pipe_nbit.sv
// tb_rca_pipe_nbit: randomized self-checking bench for rca_pipe_nbit against an arithmetic reference model.
module tb_rca_pipe_nbit;
    import rca_pkg::*;
    localparam int W = 32;
    localparam int S = 4;
`ifdef RCA_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rca_pipe_nbit_if #(.WIDTH(W)) bus ();
    rca_pipe_nbit #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic ovf_o;
`ifdef RCA_OVF_EN
    assign ovf_o = bus.overflow;
`else
    assign ovf_o = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] o_res, exp_v;
    logic o_vld, o_xfer, o_acc, o_rdy, have_exp;

    // {overflow, carry, sum} of a+b+cs from plain wide arithmetic and sign rules
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cs);
        logic [W:0] t;
        logic v;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cs};
        v = OVF && (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {v, t};
    endfunction

    task automatic step();
        @(negedge clk);
        o_vld    = bus.out_valid;
        o_rdy    = bus.in_ready;
        o_res    = {ovf_o, bus.carry, bus.sum};
        o_xfer   = bus.out_valid && bus.out_ready;
        o_acc    = bus.in_valid && bus.in_ready;
        have_exp = 1'b0;
        if (o_xfer && exp_q.size() > 0) begin
            exp_v    = exp_q.pop_front();
            have_exp = 1'b1;
        end
        if (o_acc) exp_q.push_back(model(bus.a, bus.b, bus.carry_start));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_chk += 4;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
        if (bus.sum !== '0) begin n_fail++; $display("FAIL reset sum got %h want 0", bus.sum); end
        if ({bus.carry, ovf_o} !== 2'b00) begin n_fail++; $display("FAIL reset carry/ovf got %b want 00", {bus.carry, ovf_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic cs,
                               input logic [W-1:0] es, input logic ec, input logic eo);
        logic got;
        logic [W+1:0] want;
        want = {OVF & eo, ec, es};
        bus.a = a; bus.b = b; bus.carry_start = cs; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        got = 1'b0;
        for (int j = 1; j <= 20 && !got; j++) begin
            step();
            if (o_vld) begin
                got = 1'b1;
                n_chk += 2;
                if (j != S) begin n_fail++; $display("FAIL single latency a=%h got %0d want %0d", a, j, S); end
                if (o_res !== want) begin n_fail++; $display("FAIL single a=%h b=%h cs=%b got %h want %h", a, b, cs, o_res, want); end
            end
        end
        if (!got) begin n_chk++; n_fail++; $display("FAIL single timeout a=%h b=%h", a, b); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, recv = 0, cyc = 0, first = -1, last = -1;
        bus.out_ready = 1'b1;
        while (recv < 100 && cyc < 400) begin
            if (sent < 100) begin
                bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.carry_start = 1'($urandom_range(0, 1));
            end else bus.in_valid = 1'b0;
            step();
            cyc++;
            if (o_acc) sent++;
            if (o_xfer) begin
                recv++;
                if (first < 0) first = cyc;
                last = cyc;
                n_chk++;
                if (!have_exp || o_res !== exp_v) begin n_fail++; $display("FAIL b2b beat %0d got %h want %h", recv, o_res, exp_v); end
            end
        end
        bus.in_valid = 1'b0;
        n_chk += 2;
        if (recv != 100) begin n_fail++; $display("FAIL b2b count got %0d want 100", recv); end
        if (last - first + 1 != 100) begin n_fail++; $display("FAIL b2b throughput span got %0d want 100", last - first + 1); end
    endtask

    task automatic test_stall();
        int acc = 0, rec = 0;
        logic [W+1:0] snap;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.carry_start = 1'($urandom_range(0, 1));
            step();
            if (o_acc) acc++;
            if (o_xfer) begin
                rec++; n_chk++;
                if (!have_exp || o_res !== exp_v) begin n_fail++; $display("FAIL stall fill got %h want %h", o_res, exp_v); end
            end
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.a = $urandom; bus.b = $urandom;
            step();
            if (o_acc) acc++;
            if (i == 0) snap = o_res;
            n_chk += 3;
            if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL stall in_ready cycle %0d got %b want 0", i, o_rdy); end
            if (o_vld !== 1'b1) begin n_fail++; $display("FAIL stall out_valid cycle %0d got %b want 1", i, o_vld); end
            if (o_res !== snap) begin n_fail++; $display("FAIL stall hold cycle %0d got %h want %h", i, o_res, snap); end
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40 && (exp_q.size() > 0 || o_vld); i++) begin
            step();
            if (o_xfer) begin
                rec++; n_chk++;
                if (!have_exp || o_res !== exp_v) begin n_fail++; $display("FAIL stall drain got %h want %h", o_res, exp_v); end
            end
        end
        n_chk++;
        if (rec != acc || exp_q.size() != 0) begin n_fail++; $display("FAIL stall count got %0d want %0d", rec, acc); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.carry_start = 1'($urandom_range(0, 1));
            step();
            if (o_xfer) begin
                n_chk++;
                if (!have_exp || o_res !== exp_v) begin n_fail++; $display("FAIL rstmid pre got %h want %h", o_res, exp_v); end
            end
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid busy out_valid got %b want 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid drop out_valid got %b want 0", bus.out_valid); end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_vld) seen++;
        end
        n_chk++;
        if (seen != 0) begin n_fail++; $display("FAIL rstmid stale results got %0d want 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.carry_start = 1'b0; bus.out_ready = 1'b1;
        test_reset();
        test_single(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        test_single(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        test_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        test_single(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        test_single(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0, 1'b0);
        test_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        test_single(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
